// File: rtl/phased_cache_pkg.sv
// Shared types and defaults for the phased cache request/fill controller.
// Holds the controller state enum and the lowest-set-bit helper.
package phased_cache_pkg;

  localparam int WAYS_DEF    = 4;
  localparam int INDEX_W_DEF = 2;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE,
    TAG,
    MREQ,
    FILL,
    DATA
  } state_e;

  function automatic logic [31:0] lowest_bit(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/victim_select.sv
// Victim way choice: first invalid way, else the per-set round-robin pointer.
// Pointers advance only on fills that were chosen by the pointer.
module victim_select
  import phased_cache_pkg::*;
#(
  parameter int WAYS    = WAYS_DEF,
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic [WAYS-1:0]    way_valid,
  input  logic               fill,
  output logic [WAYS-1:0]    victim,
  output logic               from_ptr
);

  localparam int SETS = 2 ** INDEX_W;
  localparam int PW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [PW-1:0]   ptr_q [SETS];
  logic [PW-1:0]   ptr_d [SETS];
  logic [WAYS-1:0] inval;

  assign inval    = WAYS'(lowest_bit(32'(~way_valid)));
  assign from_ptr = &way_valid;
  assign victim   = from_ptr ? (WAYS'(1) << ptr_q[index]) : inval;

  always_comb begin
    ptr_d = ptr_q;
    if (fill) begin
      if (ptr_q[index] == PW'(WAYS - 1))
        ptr_d[index] = '0;
      else
        ptr_d[index] = ptr_q[index] + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SETS; i++) ptr_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/phased_cache_ctrl.sv
// Phased cache request/fill controller: tag phase, then data phase or
// memory fetch plus fill into a victim way; all outputs are registered.
module phased_cache_ctrl
  import phased_cache_pkg::*;
#(
  parameter int WAYS    = WAYS_DEF,
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [INDEX_W-1:0]    req_index,
  output logic                  req_ready,
  output logic [INDEX_W-1:0]    index,
  output logic [2**INDEX_W-1:0] index_dec,
  input  logic [WAYS-1:0]       way_valid,
  input  logic [WAYS-1:0]       way_tag_match,
  output logic [WAYS-1:0]       load,
  output logic [WAYS-1:0]       data_rd_en,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);

  localparam int SETS = 2 ** INDEX_W;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [WAYS-1:0]    victim_q, victim_d;
  logic               vptr_q, vptr_d;
  logic [WAYS-1:0]    load_q, load_d;
  logic [WAYS-1:0]    rd_q, rd_d;
  logic               mem_req_q, mem_req_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_hit_q, resp_hit_d;
  logic               req_ready_q, req_ready_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [WAYS-1:0] hit_vec;
  logic [WAYS-1:0] hit_one;
  logic [WAYS-1:0] victim;
  logic            from_ptr;
  logic            fill;

  assign hit_vec = way_valid & way_tag_match;
  assign hit_one = WAYS'(lowest_bit(32'(hit_vec)));
  assign fill    = (state_q == FILL) && vptr_q;

  victim_select #(
    .WAYS    (WAYS),
    .INDEX_W (INDEX_W)
  ) u_victim (
    .clk       (clk),
    .reset     (reset),
    .index     (index_q),
    .way_valid (way_valid),
    .fill      (fill),
    .victim    (victim),
    .from_ptr  (from_ptr)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    victim_d     = victim_q;
    vptr_d       = vptr_q;
    load_d       = '0;
    rd_d         = '0;
    mem_req_d    = 1'b0;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    req_ready_d  = req_ready_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          index_d     = req_index;
          state_d     = TAG;
          req_ready_d = 1'b0;
        end
      end
      TAG: begin
        if (|hit_vec) begin
          state_d      = DATA;
          rd_d         = hit_one;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          if (hit_cnt_q != {CNT_W{1'b1}})
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else begin
          state_d   = MREQ;
          victim_d  = victim;
          vptr_d    = from_ptr;
          mem_req_d = 1'b1;
          if (miss_cnt_q != {CNT_W{1'b1}})
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
      end
      MREQ: begin
        if (mem_ack) begin
          state_d = FILL;
          load_d  = victim_q;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      FILL: begin
        state_d      = DATA;
        rd_d         = victim_q;
        resp_valid_d = 1'b1;
      end
      DATA: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      index_q      <= '0;
      victim_q     <= '0;
      vptr_q       <= 1'b0;
      load_q       <= '0;
      rd_q         <= '0;
      mem_req_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      victim_q     <= victim_d;
      vptr_q       <= vptr_d;
      load_q       <= load_d;
      rd_q         <= rd_d;
      mem_req_q    <= mem_req_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      req_ready_q  <= req_ready_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign index      = index_q;
  assign index_dec  = SETS'(1) << index_q;
  assign load       = load_q;
  assign data_rd_en = rd_q;
  assign mem_req    = mem_req_q;
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_phased_cache_ctrl.sv
// Directed bench for phased_cache_ctrl: hits, misses, victim choice,
// memory wait, mid-operation reset and counter saturation.
module tb_phased_cache_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_index = '0;
  logic       req_ready;
  logic [1:0] index;
  logic [3:0] index_dec;
  logic [3:0] way_valid = '0;
  logic [3:0] way_tag_match = '0;
  logic [3:0] load;
  logic [3:0] data_rd_en;
  logic       mem_req;
  logic       mem_ack = 1'b0;
  logic       resp_valid;
  logic       resp_hit;
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phased_cache_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_index     (req_index),
    .req_ready     (req_ready),
    .index         (index),
    .index_dec     (index_dec),
    .way_valid     (way_valid),
    .way_tag_match (way_tag_match),
    .load          (load),
    .data_rd_en    (data_rd_en),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and records what the DUT did; no checking here.
  task automatic run_req(
    input  logic [1:0] idx,
    input  logic [3:0] v,
    input  logic [3:0] m,
    input  int         ack_n,
    output logic [3:0] ld,
    output int         ld_cyc,
    output logic [3:0] rd,
    output int         resp_cyc,
    output logic       hit,
    output int         mreq_n,
    output logic       rdy_bad
  );
    ld = '0; ld_cyc = -1; rd = '0; resp_cyc = -1;
    hit = 1'b0; mreq_n = 0; rdy_bad = 1'b0;
    req_index = idx; way_valid = v; way_tag_match = m;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 60 && resp_cyc < 0; c++) begin
      if (req_ready) rdy_bad = 1'b1;
      if (load != '0) begin ld = load; ld_cyc = c; end
      if (mem_req) begin
        mreq_n++;
        mem_ack = (mreq_n == ack_n);
      end else begin
        mem_ack = 1'b0;
      end
      if (resp_valid) begin
        resp_cyc = c; rd = data_rd_en; hit = resp_hit;
      end
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
    checks++;
    if ({index, index_dec} !== 6'b00_0001) begin
      errors++; $display("FAIL reset_index got %b/%b want 00/0001", index, index_dec);
    end
    checks++;
    if ({load, data_rd_en, mem_req, resp_valid, resp_hit} !== 11'd0) begin
      errors++; $display("FAIL reset_outs got %b %b %b %b %b want zeros",
        load, data_rd_en, mem_req, resp_valid, resp_hit);
    end
    checks++;
    if ({hit_cnt, miss_cnt} !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_miss_invalid();
    logic [3:0] ld, rd; int lc, rc, mn; logic h, rb;
    run_req(2'd2, 4'b0000, 4'b0000, 1, ld, lc, rd, rc, h, mn, rb);
    checks++;
    if (ld !== 4'b0001 || lc != 3) begin
      errors++; $display("FAIL miss_load got %b@%0d want 0001@3", ld, lc);
    end
    checks++;
    if (rc != 4 || h !== 1'b0 || rd !== 4'b0001) begin
      errors++; $display("FAIL miss_resp got cyc%0d hit%b rd%b want cyc4 hit0 rd0001", rc, h, rd);
    end
    checks++;
    if (miss_cnt !== 8'd1 || rb !== 1'b0 || mn != 1) begin
      errors++; $display("FAIL miss_cnt got %0d rdybad%b mreq%0d want 1 0 1", miss_cnt, rb, mn);
    end
    run_req(2'd0, 4'b1011, 4'b0000, 1, ld, lc, rd, rc, h, mn, rb);
    checks++;
    if (ld !== 4'b0100) begin
      errors++; $display("FAIL first_invalid got %b want 0100", ld);
    end
  endtask

  task automatic test_hit();
    logic [3:0] ld, rd; int lc, rc, mn; logic h, rb;
    run_req(2'd1, 4'b1111, 4'b0100, 1, ld, lc, rd, rc, h, mn, rb);
    checks++;
    if (rd !== 4'b0100 || rc != 2 || h !== 1'b1) begin
      errors++; $display("FAIL hit_resp got rd%b cyc%0d hit%b want 0100 2 1", rd, rc, h);
    end
    checks++;
    if (hit_cnt !== 8'd1 || mn != 0 || ld !== 4'b0000) begin
      errors++; $display("FAIL hit_side got cnt%0d mreq%0d ld%b want 1 0 0000", hit_cnt, mn, ld);
    end
    checks++;
    if (index !== 2'd1 || index_dec !== 4'b0010) begin
      errors++; $display("FAIL hit_index got %0d/%b want 1/0010", index, index_dec);
    end
    run_req(2'd1, 4'b1101, 4'b0111, 1, ld, lc, rd, rc, h, mn, rb);
    checks++;
    if (rd !== 4'b0001 || h !== 1'b1 || hit_cnt !== 8'd2) begin
      errors++; $display("FAIL multi_hit got rd%b hit%b cnt%0d want 0001 1 2", rd, h, hit_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ld, rd; int lc, rc, mn; logic h, rb;
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      run_req(2'd3, 4'b1111, 4'b0000, 1, ld, lc, rd, rc, h, mn, rb);
      checks++;
      if (ld !== exp_seq[i]) begin
        errors++; $display("FAIL rr_set3_%0d got %b want %b", i, ld, exp_seq[i]);
      end
    end
    run_req(2'd2, 4'b1111, 4'b0000, 1, ld, lc, rd, rc, h, mn, rb);
    checks++;
    if (ld !== 4'b0001) begin
      errors++; $display("FAIL rr_set2 got %b want 0001", ld);
    end
    run_req(2'd0, 4'b1111, 4'b0000, 1, ld, lc, rd, rc, h, mn, rb);
    checks++;
    if (ld !== 4'b0001 || miss_cnt !== 8'd9) begin
      errors++; $display("FAIL rr_set0 got %b cnt%0d want 0001 9", ld, miss_cnt);
    end
  endtask

  task automatic test_mem_wait();
    logic [3:0] ld, rd; int lc, rc, mn; logic h, rb;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_ack got rdy%b mreq%b want 1 0", req_ready, mem_req);
    end
    run_req(2'd1, 4'b1111, 4'b0000, 5, ld, lc, rd, rc, h, mn, rb);
    checks++;
    if (mn != 5 || rb !== 1'b0) begin
      errors++; $display("FAIL wait_mreq got %0d cycles rdybad%b want 5 0", mn, rb);
    end
    checks++;
    if (ld !== 4'b0001 || lc != 7 || rc != 8) begin
      errors++; $display("FAIL wait_lat got ld%b@%0d resp@%0d want 0001@7 8", ld, lc, rc);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ld, rd; int lc, rc, mn; logic h, rb;
    logic saw_resp;
    req_index = 2'd3; way_valid = 4'b1111; way_tag_match = 4'b0000;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    checks++;
    if (mem_req !== 1'b1 || miss_cnt !== 8'd11) begin
      errors++; $display("FAIL pre_reset got mreq%b cnt%0d want 1 11", mem_req, miss_cnt);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || load !== 4'b0000 || req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got mreq%b ld%b rdy%b want 0 0000 1", mem_req, load, req_ready);
    end
    checks++;
    if ({hit_cnt, miss_cnt} !== 16'd0) begin
      errors++; $display("FAIL mid_reset_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt);
    end
    step();
    reset = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid || mem_req) saw_resp = 1'b1;
      step();
    end
    checks++;
    if (saw_resp !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_quiet got resp%b rdy%b want 0 1", saw_resp, req_ready);
    end
    run_req(2'd3, 4'b1111, 4'b0000, 1, ld, lc, rd, rc, h, mn, rb);
    checks++;
    if (ld !== 4'b0001 || rc != 4) begin
      errors++; $display("FAIL ptr_cleared got %b resp@%0d want 0001 4", ld, rc);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] ld, rd; int lc, rc, mn; logic h, rb;
    for (int i = 1; i <= 300; i++) begin
      run_req(2'd0, 4'b1111, 4'b1000, 1, ld, lc, rd, rc, h, mn, rb);
      if (i == 254) begin
        checks++;
        if (hit_cnt !== 8'd254) begin
          errors++; $display("FAIL sat_254 got %0d want 254", hit_cnt);
        end
      end
    end
    checks++;
    if (hit_cnt !== 8'd255 || miss_cnt !== 8'd1) begin
      errors++; $display("FAIL sat_300 got %0d/%0d want 255/1", hit_cnt, miss_cnt);
    end
    checks++;
    if (rd !== 4'b1000 || h !== 1'b1) begin
      errors++; $display("FAIL sat_last got rd%b hit%b want 1000 1", rd, h);
    end
  endtask

  initial begin
    test_reset();
    test_miss_invalid();
    test_hit();
    test_round_robin();
    test_mem_wait();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
